// File: rtl/ppu_regs_pkg.sv
// Shared definitions for the PPU register window: register indices, the VRAM
// access state encoding and the V increment steps.
package ppu_regs_pkg;

  localparam logic [2:0] REG_CTRL0  = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_SCROLL = 3'd5;
  localparam logic [2:0] REG_ADDR   = 3'd6;
  localparam logic [2:0] REG_DATA   = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ALE,
    ACC,
    INC
  } vram_state_e;

  localparam int unsigned INC_1  = 1;
  localparam int unsigned INC_32 = 32;

endpackage

// File: rtl/ppu_scroll_addr_regs.sv
// Scroll/address register file: shared write toggle, T and V address registers,
// fine X, and the V load/increment muxing.
module ppu_scroll_addr_regs
  import ppu_regs_pkg::*;
#(
  parameter int unsigned VW = 15
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic          rd_en_i,
  input  logic [2:0]    rs_i,
  input  logic [7:0]    din_i,
  input  logic          inc_en_i,
  input  logic          inc_32_i,
  output logic [VW-1:0] v_o,
  output logic [2:0]    fine_x_o
);

  logic          toggle_q, toggle_d;
  logic [VW-1:0] t_q, t_d;
  logic [VW-1:0] v_q, v_d;
  logic [2:0]    fine_x_q, fine_x_d;
  logic [VW-1:0] inc_step;

  assign inc_step = inc_32_i ? VW'(INC_32) : VW'(INC_1);

  always_comb begin
    toggle_d = toggle_q;
    t_d      = t_q;
    v_d      = v_q;
    fine_x_d = fine_x_q;

    if (inc_en_i) begin
      v_d = v_q + inc_step;
    end

    // A register load of V is applied after the increment so it takes priority.
    if (wr_en_i) begin
      case (rs_i)
        REG_CTRL0: begin
          t_d[11:10] = din_i[1:0];
        end
        REG_SCROLL: begin
          if (!toggle_q) begin
            t_d[4:0] = din_i[7:3];
            fine_x_d = din_i[2:0];
            toggle_d = 1'b1;
          end else begin
            t_d[14:12] = din_i[2:0];
            t_d[9:5]   = din_i[7:3];
            toggle_d   = 1'b0;
          end
        end
        REG_ADDR: begin
          if (!toggle_q) begin
            t_d[13:8] = din_i[5:0];
            t_d[14]   = 1'b0;
            toggle_d  = 1'b1;
          end else begin
            t_d[7:0] = din_i;
            v_d      = {t_q[VW-1:8], din_i};
            toggle_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (rd_en_i && (rs_i == REG_STATUS)) begin
      toggle_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      toggle_q <= 1'b0;
      t_q      <= '0;
      v_q      <= '0;
      fine_x_q <= 3'd0;
    end else begin
      toggle_q <= toggle_d;
      t_q      <= t_d;
      v_q      <= v_d;
      fine_x_q <= fine_x_d;
    end
  end

  assign v_o      = v_q;
  assign fine_x_o = fine_x_q;

endmodule

// File: rtl/ppu_vram_access_ctrl.sv
// CPU-side VRAM access sequencer: $2007 FSM, read buffer, bus strobes and
// arbitration against rendering fetches.
module ppu_vram_access_ctrl
  import ppu_regs_pkg::*;
#(
  parameter int unsigned AW = 14,
  parameter int unsigned VW = 15
) (
  input  logic          CLK,
  input  logic          n_RES,
  input  logic          reg_stb,
  input  logic [2:0]    RS,
  input  logic          RnW,
  input  logic [7:0]    cpu_din,
  input  logic          I_1_32,
  input  logic          render_req,
  input  logic [7:0]    vram_din,
  output logic [7:0]    cpu_dout,
  output logic [AW-1:0] vram_addr,
  output logic          ale,
  output logic          n_rd,
  output logic          n_wr,
  output logic [7:0]    vram_dout,
  output logic          render_gnt,
  output logic          busy,
  output logic          ovr,
  output logic [2:0]    fine_x,
  output logic [VW-1:0] v_out
);

  vram_state_e   state_q, state_d;
  logic          rd_dir_q, rd_dir_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rd_buf_q, rd_buf_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          ale_q, ale_d;
  logic          n_rd_q, n_rd_d;
  logic          n_wr_q, n_wr_d;
  logic [7:0]    vram_dout_q, vram_dout_d;
  logic [AW-1:0] vram_addr_q, vram_addr_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;

  logic          data_stb;
  logic          inc_en;
  logic [VW-1:0] v_cur;

  assign data_stb = reg_stb && (RS == REG_DATA);
  assign inc_en   = (state_q == INC);

  ppu_scroll_addr_regs #(
    .VW(VW)
  ) u_regs (
    .clk_i   (CLK),
    .rst_ni  (n_RES),
    .wr_en_i (reg_stb & ~RnW),
    .rd_en_i (reg_stb & RnW),
    .rs_i    (RS),
    .din_i   (cpu_din),
    .inc_en_i(inc_en),
    .inc_32_i(I_1_32),
    .v_o     (v_cur),
    .fine_x_o(fine_x)
  );

  always_comb begin
    state_d     = state_q;
    rd_dir_d    = rd_dir_q;
    wdata_d     = wdata_q;
    rd_buf_d    = rd_buf_q;
    cpu_dout_d  = cpu_dout_q;
    ale_d       = ale_q;
    n_rd_d      = n_rd_q;
    n_wr_d      = n_wr_q;
    vram_dout_d = vram_dout_q;
    vram_addr_d = vram_addr_q;
    busy_d      = busy_q;
    // A data-port strobe that arrives mid-sequence is discarded and flagged.
    ovr_d       = data_stb & busy_q;

    unique case (state_q)
      IDLE: begin
        if (data_stb) begin
          state_d  = WAIT;
          busy_d   = 1'b1;
          rd_dir_d = RnW;
          wdata_d  = cpu_din;
          if (RnW) begin
            cpu_dout_d = rd_buf_q;
          end
        end
      end
      WAIT: begin
        if (!render_req) begin
          state_d     = ALE;
          ale_d       = 1'b1;
          vram_addr_d = v_cur[AW-1:0];
        end
      end
      ALE: begin
        state_d = ACC;
        ale_d   = 1'b0;
        if (rd_dir_q) begin
          n_rd_d = 1'b0;
        end else begin
          n_wr_d      = 1'b0;
          vram_dout_d = wdata_q;
        end
      end
      ACC: begin
        state_d = INC;
        n_rd_d  = 1'b1;
        n_wr_d  = 1'b1;
        if (rd_dir_q) begin
          rd_buf_d = vram_din;
        end
      end
      INC: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state_q     <= IDLE;
      rd_dir_q    <= 1'b0;
      wdata_q     <= 8'd0;
      rd_buf_q    <= 8'd0;
      cpu_dout_q  <= 8'd0;
      ale_q       <= 1'b0;
      n_rd_q      <= 1'b1;
      n_wr_q      <= 1'b1;
      vram_dout_q <= 8'd0;
      vram_addr_q <= '0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_dir_q    <= rd_dir_d;
      wdata_q     <= wdata_d;
      rd_buf_q    <= rd_buf_d;
      cpu_dout_q  <= cpu_dout_d;
      ale_q       <= ale_d;
      n_rd_q      <= n_rd_d;
      n_wr_q      <= n_wr_d;
      vram_dout_q <= vram_dout_d;
      vram_addr_q <= vram_addr_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
    end
  end

  // Rendering may take the bus only before the CPU sequence commits at ALE.
  assign render_gnt = n_RES & render_req & ((state_q == IDLE) | (state_q == WAIT));

  assign cpu_dout  = cpu_dout_q;
  assign vram_addr = vram_addr_q;
  assign ale       = ale_q;
  assign n_rd      = n_rd_q;
  assign n_wr      = n_wr_q;
  assign vram_dout = vram_dout_q;
  assign busy      = busy_q;
  assign ovr       = ovr_q;
  assign v_out     = v_cur;

endmodule

// File: tb/tb_ppu_vram_access_ctrl.sv
// Directed bench for ppu_vram_access_ctrl with a cycle-level behavioural model
// compared every cycle, plus literal expectations at key points.
module tb_ppu_vram_access_ctrl;

  logic        CLK = 1'b0;
  logic        n_RES = 1'b0;
  logic        reg_stb = 1'b0;
  logic [2:0]  RS = 3'd0;
  logic        RnW = 1'b0;
  logic [7:0]  cpu_din = 8'd0;
  logic        I_1_32 = 1'b0;
  logic        render_req = 1'b0;
  logic [7:0]  vram_din;
  logic [7:0]  cpu_dout;
  logic [13:0] vram_addr;
  logic        ale, n_rd, n_wr;
  logic [7:0]  vram_dout;
  logic        render_gnt, busy, ovr;
  logic [2:0]  fine_x;
  logic [14:0] v_out;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [0:16383];

  always #5 CLK = ~CLK;

  assign vram_din = mem[vram_addr];

  ppu_vram_access_ctrl #(
    .AW(14),
    .VW(15)
  ) dut (
    .CLK       (CLK),
    .n_RES     (n_RES),
    .reg_stb   (reg_stb),
    .RS        (RS),
    .RnW       (RnW),
    .cpu_din   (cpu_din),
    .I_1_32    (I_1_32),
    .render_req(render_req),
    .vram_din  (vram_din),
    .cpu_dout  (cpu_dout),
    .vram_addr (vram_addr),
    .ale       (ale),
    .n_rd      (n_rd),
    .n_wr      (n_wr),
    .vram_dout (vram_dout),
    .render_gnt(render_gnt),
    .busy      (busy),
    .ovr       (ovr),
    .fine_x    (fine_x),
    .v_out     (v_out)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: register file as plain integers; an access is either queued behind
  // rendering (m_pending) or running, with m_run counting cycles since its
  // address phase began (0 address, 1 data, 2 increment; -1 none).
  int m_t = 0, m_v = 0, m_fx = 0, m_tog = 0, m_buf = 0, m_dout = 0;
  int m_addr = 0, m_wd = 0, m_run = -1;
  bit m_pending = 0, m_rd = 0, m_ovr = 0;
  int nv;
  bit s7;

  always @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      m_t = 0; m_v = 0; m_fx = 0; m_tog = 0; m_buf = 0; m_dout = 0;
      m_addr = 0; m_wd = 0; m_run = -1; m_pending = 0; m_rd = 0; m_ovr = 0;
    end else begin
      s7 = reg_stb && (RS == 3'd7);
      nv = m_v;
      if (m_run == 2) nv = (m_v + (I_1_32 ? 32 : 1)) % 32768;
      if (reg_stb && !RnW) begin
        if (RS == 3'd0) begin
          m_t = (m_t & ~('h3 << 10)) | ((cpu_din & 3) << 10);
        end else if (RS == 3'd5) begin
          if (m_tog == 0) begin
            m_t = (m_t & ~'h1F) | (cpu_din >> 3);
            m_fx = cpu_din & 7;
          end else begin
            m_t = (m_t & ~('h7 << 12) & ~('h1F << 5)) | ((cpu_din & 7) << 12) | ((cpu_din >> 3) << 5);
          end
          m_tog = 1 - m_tog;
        end else if (RS == 3'd6) begin
          if (m_tog == 0) begin
            m_t = (m_t & 'hFF) | ((cpu_din & 'h3F) << 8);
          end else begin
            m_t = (m_t & 'h7F00) | cpu_din;
            nv = m_t;
          end
          m_tog = 1 - m_tog;
        end
      end
      if (reg_stb && RnW && (RS == 3'd2)) m_tog = 0;
      m_ovr = s7 && (m_pending || m_run >= 0);
      if (m_run == 2) begin
        m_run = -1;
      end else if (m_run >= 0) begin
        if (m_run == 1 && m_rd) m_buf = mem[m_addr];
        m_run++;
      end else if (m_pending) begin
        if (!render_req) begin
          m_pending = 0;
          m_run = 0;
          m_addr = m_v % 16384;
        end
      end else if (s7) begin
        m_pending = 1;
        m_rd = RnW;
        m_wd = cpu_din;
        if (RnW) m_dout = m_buf;
      end
      m_v = nv;
    end
  end

  always @(negedge CLK) begin
    if (n_RES) begin
      chk("cmp_busy", busy, (m_pending || m_run >= 0) ? 1 : 0);
      chk("cmp_ale", ale, (m_run == 0) ? 1 : 0);
      chk("cmp_n_rd", n_rd, (m_run == 1 && m_rd) ? 0 : 1);
      chk("cmp_n_wr", n_wr, (m_run == 1 && !m_rd) ? 0 : 1);
      chk("cmp_gnt", render_gnt, (render_req && m_run < 0) ? 1 : 0);
      chk("cmp_ovr", ovr, m_ovr);
      chk("cmp_cpu_dout", cpu_dout, m_dout);
      chk("cmp_v_out", v_out, m_v);
      chk("cmp_fine_x", fine_x, m_fx);
      if (m_run == 0 || m_run == 1) chk("cmp_vram_addr", vram_addr, m_addr);
      if (m_run == 1 && !m_rd) chk("cmp_vram_dout", vram_dout, m_wd);
    end
  end

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  task automatic reg_wr(input logic [2:0] rs, input logic [7:0] d);
    reg_stb = 1'b1; RS = rs; RnW = 1'b0; cpu_din = d;
    cyc();
    reg_stb = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] rs);
    reg_stb = 1'b1; RS = rs; RnW = 1'b1;
    cyc();
    reg_stb = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      cyc();
    end
    chk("wait_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 7 + 3);
    mem[14'h2000] = 8'h11;
    mem[14'h2001] = 8'h22;
    mem[14'h2002] = 8'h33;

    cyc(); cyc();
    chk("rst_v", v_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_n_rd", n_rd, 1);
    chk("rst_n_wr", n_wr, 1);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_gnt", render_gnt, 0);
    n_RES = 1'b1;
    cyc();

    // Addressed write with +1 increment
    reg_wr(3'd6, 8'h21);
    reg_wr(3'd6, 8'h08);
    chk("t1_v", v_out, 'h2108);
    reg_wr(3'd7, 8'h5A);
    chk("t1_busy", busy, 1);
    cyc();
    chk("t1_ale", ale, 1);
    chk("t1_addr", vram_addr, 'h2108);
    cyc();
    chk("t1_n_wr", n_wr, 0);
    chk("t1_dout", vram_dout, 'h5A);
    cyc();
    cyc();
    chk("t1_v_inc", v_out, 'h2109);
    chk("t1_idle", busy, 0);

    // Buffered reads
    reg_wr(3'd6, 8'h20);
    reg_wr(3'd6, 8'h00);
    reg_rd(3'd7);
    chk("t2_rd0", cpu_dout, 'h00);
    wait_idle();
    reg_rd(3'd7);
    chk("t2_rd1", cpu_dout, 'h11);
    wait_idle();
    reg_rd(3'd7);
    chk("t2_rd2", cpu_dout, 'h22);
    wait_idle();
    chk("t2_v", v_out, 'h2003);

    // Status read clears the shared toggle
    reg_wr(3'd6, 8'h3F);
    reg_rd(3'd2);
    reg_wr(3'd6, 8'h00);
    chk("t3_v_same", v_out, 'h2003);
    reg_wr(3'd6, 8'h44);
    chk("t3_v_new", v_out, 'h0044);

    // Rendering holds the bus, then the CPU sequence runs unpreempted
    render_req = 1'b1;
    reg_wr(3'd7, 8'h77);
    for (int i = 0; i < 5; i++) begin
      chk("t4_gnt_wait", render_gnt, 1);
      chk("t4_no_ale", ale, 0);
      cyc();
    end
    render_req = 1'b0;
    cyc();
    chk("t4_ale", ale, 1);
    chk("t4_addr", vram_addr, 'h0044);
    render_req = 1'b1;
    chk("t4_gnt_ale", render_gnt, 0);
    cyc();
    chk("t4_gnt_acc", render_gnt, 0);
    cyc();
    chk("t4_gnt_inc", render_gnt, 0);
    render_req = 1'b0;
    cyc();
    chk("t4_v", v_out, 'h0045);

    // Build V=0x7FF0, then +32 wrap and a dropped strobe during the data phase
    reg_rd(3'd2);
    reg_wr(3'd5, 8'hFF);
    reg_wr(3'd5, 8'hFF);
    reg_wr(3'd0, 8'h03);
    reg_wr(3'd5, 8'h03);
    reg_wr(3'd6, 8'hF0);
    chk("t5_v", v_out, 'h7FF0);
    chk("t5_fine_x", fine_x, 3);
    I_1_32 = 1'b1;
    reg_wr(3'd7, 8'h5A);
    cyc();
    chk("t5_addr", vram_addr, 'h3FF0);
    cyc();
    chk("t5_n_wr", n_wr, 0);
    reg_wr(3'd7, 8'h99);
    chk("t5_ovr", ovr, 1);
    cyc();
    chk("t5_ovr_gone", ovr, 0);
    chk("t5_v_wrap", v_out, 'h0010);
    cyc();
    cyc();
    chk("t5_no_extra", busy, 0);

    // Asynchronous reset during the data phase of a read
    I_1_32 = 1'b0;
    reg_wr(3'd6, 8'h20);
    reg_wr(3'd6, 8'h01);
    reg_rd(3'd7);
    chk("t6_buf", cpu_dout, 'h33);
    cyc();
    cyc();
    chk("t6_n_rd", n_rd, 0);
    n_RES = 1'b0;
    #1;
    chk("t6_rst_n_rd", n_rd, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_v", v_out, 0);
    chk("t6_rst_dout", cpu_dout, 0);
    cyc();
    n_RES = 1'b1;
    cyc();
    reg_rd(3'd7);
    chk("t6_buf_cleared", cpu_dout, 0);
    wait_idle();
    chk("t6_v", v_out, 'h0001);

    // Address load on the increment cycle wins over the increment
    reg_wr(3'd6, 8'h12);
    reg_wr(3'd7, 8'h01);
    cyc();
    chk("t7_addr", vram_addr, 'h0001);
    cyc();
    cyc();
    reg_wr(3'd6, 8'h34);
    chk("t7_v", v_out, 'h1234);
    chk("t7_idle", busy, 0);
    cyc();
    chk("t7_v_hold", v_out, 'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
